// File: rtl/luma_out_collector.sv
// luma_out_collector: per-channel holding registers, round-robin arbiter,
// rounding right shift and a show-ahead output FIFO tagged with source channel.
// Optional feature macro COLLECTOR_CLIP_EN: clip the rounded value to 0..2^OUT_W-1
// before it is queued (otherwise the low OUT_W bits are queued, wrapping).
module luma_out_collector #(
    parameter int N_CH  = 4,
    parameter int IN_W  = 17,
    parameter int OUT_W = 8,
    parameter int SHIFT = 6,
    parameter int DEPTH = 8,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      vin,
    input  logic [N_CH*IN_W-1:0] din,
    input  logic                 rdy,
    input  logic                 clr_ovf,
    output logic                 vout,
    output logic [OUT_W-1:0]     dout,
    output logic [CW-1:0]        dout_ch,
    output logic [AW:0]          level,
    output logic [N_CH-1:0]      ovf
);
    localparam logic [IN_W:0] RND    = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);

    logic [N_CH-1:0]  r_hold_v;
    logic [IN_W-1:0]  r_hold_d [N_CH];
    logic [CW-1:0]    r_start;
    logic [N_CH-1:0]  r_ovf;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [OUT_W-1:0] r_mem_d [DEPTH];
    logic [CW-1:0]    r_mem_c [DEPTH];

    logic             w_pop;
    logic             w_push;
    logic             w_gnt_v;
    logic [CW-1:0]    w_gnt;
    logic [N_CH-1:0]  w_drain;
    logic [N_CH-1:0]  w_load;
    logic [N_CH-1:0]  w_drop;
    logic signed [IN_W:0] w_sum;
    logic [OUT_W-1:0] w_pix;

    assign w_pop  = (r_level != '0) && rdy;
    // a full FIFO can still take a sample when its head leaves in the same cycle
    assign w_push = w_gnt_v && ((r_level < L_FULL) || w_pop);

    // round-robin search for the first full holding register starting at r_start
    always_comb begin : arb
        int j;
        j       = 0;
        w_gnt_v = 1'b0;
        w_gnt   = '0;
        for (int i = 0; i < N_CH; i++) begin
            j = int'(r_start) + i;
            if (j >= N_CH)
                j = j - N_CH;
            if (!w_gnt_v && r_hold_v[CW'(j)]) begin
                w_gnt_v = 1'b1;
                w_gnt   = CW'(j);
            end
        end
    end

    assign w_drain = w_push ? (N_CH'(1) << w_gnt) : '0;
    assign w_load  = vin & (~r_hold_v | w_drain);
    assign w_drop  = vin & r_hold_v & ~w_drain;

    // sign-extend by one bit so adding the rounding constant can never overflow
    assign w_sum = $signed({r_hold_d[w_gnt][IN_W-1], r_hold_d[w_gnt]}) + $signed(RND);

`ifdef COLLECTOR_CLIP_EN
    logic signed [IN_W:0] w_r;
    assign w_r   = w_sum >>> SHIFT;
    assign w_pix = w_r[IN_W] ? '0 : (|w_r[IN_W-1:OUT_W]) ? '1 : w_r[OUT_W-1:0];
`else
    assign w_pix = OUT_W'(w_sum >>> SHIFT);
`endif

    // holding-register occupancy, arbiter priority and sticky drop flags (set beats clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_v <= '0;
            r_start  <= '0;
            r_ovf    <= '0;
        end else begin
            r_hold_v <= (r_hold_v & ~w_drain) | w_load;
            if (w_push)
                r_start <= (w_gnt == CW'(N_CH-1)) ? '0 : w_gnt + CW'(1);
            r_ovf <= (clr_ovf ? '0 : r_ovf) | w_drop;
        end
    end

    // holding-register payloads; contents are meaningless while the valid flag is clear
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CH; k++)
            if (w_load[k])
                r_hold_d[k] <= din[k*IN_W +: IN_W];
    end

    // FIFO pointers wrap naturally at DEPTH; occupancy moves only on unbalanced push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_push != w_pop)
                r_level <= w_push ? r_level + (AW+1)'(1) : r_level - (AW+1)'(1);
        end
    end

    // FIFO storage of processed pixel and its source channel
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_d[r_wptr] <= w_pix;
            r_mem_c[r_wptr] <= w_gnt;
        end
    end

    assign vout    = (r_level != '0);
    assign dout    = vout ? r_mem_d[r_rptr] : '0;
    assign dout_ch = vout ? r_mem_c[r_rptr] : '0;
    assign level   = r_level;
    assign ovf     = r_ovf;
endmodule

// File: tb/tb_luma_out_collector.sv
// tb_luma_out_collector: vector table plus scoreboard checks for luma_out_collector.
module tb_luma_out_collector;
    localparam int N_CH = 4, IN_W = 17, OUT_W = 8, SHIFT = 6, DEPTH = 8;
`ifdef COLLECTOR_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [N_CH-1:0]      vin = '0;
    logic [N_CH*IN_W-1:0] din = '0;
    logic                 rdy = 1'b1;
    logic                 clr_ovf = 1'b0;
    logic                 vout;
    logic [OUT_W-1:0]     dout;
    logic [1:0]           dout_ch;
    logic [3:0]           level;
    logic [N_CH-1:0]      ovf;

    int total = 0;
    int bad = 0;

    typedef struct { int c; int d; } exp_t;
    exp_t sb[$];

    typedef struct { int ch; int x; int clip; int wrap; } vec_t;
    vec_t vt[10];

    luma_out_collector #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .vin(vin), .din(din), .rdy(rdy), .clr_ovf(clr_ovf),
        .vout(vout), .dout(dout), .dout_ch(dout_ch), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int ch, input int x);
        din[ch*IN_W +: IN_W] = IN_W'(x);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic wait_level(input int target, input int max);
        for (int i = 0; i < max && int'(level) != target; i++)
            tick;
        chk("wait_level", int'(level), target);
    endtask

    // scoreboard: every accepted head entry must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && vout && rdy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got dout=%0d ch=%0d want no output", dout, dout_ch);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_dout", int'(dout), e.d);
                chk("sb_ch", int'(dout_ch), e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{0, 4032, 'h3F, 'h3F};
        vt[1] = '{1, 64, 1, 1};
        vt[2] = '{2, -100, 0, 'hFE};
        vt[3] = '{3, 20000, 'hFF, 'h39};
        vt[4] = '{0, -32, 0, 0};
        vt[5] = '{1, 31, 0, 0};
        vt[6] = '{2, 32, 1, 1};
        vt[7] = '{3, -33, 0, 'hFF};
        vt[8] = '{0, 65535, 'hFF, 0};
        vt[9] = '{1, -65536, 0, 0};

        #1 reset = 1'b1;
        #2;
        chk("rst_vout", int'(vout), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_ch", int'(dout_ch), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(ovf), 0);
        tick;
        reset = 1'b0;

        // single samples: rounding, sign handling, range limits, 2-cycle latency
        for (int i = 0; i < 10; i++) begin
            int e;
            e = CLIP ? vt[i].clip : vt[i].wrap;
            set_din(vt[i].ch, vt[i].x);
            vin = N_CH'(1) << vt[i].ch;
            sb.push_back('{vt[i].ch, e});
            tick;
            vin = '0;
            chk("lat_t1_vout", int'(vout), 0);
            tick;
            chk("lat_t2_vout", int'(vout), 1);
            chk("lat_dout", int'(dout), e);
            chk("lat_ch", int'(dout_ch), vt[i].ch);
            tick;
        end
        chk("vec_sb_empty", sb.size(), 0);

        // round robin from channel 0 right after reset
        tick;
        do_reset;
        for (int k = 0; k < N_CH; k++) begin
            set_din(k, 64 * (k + 1));
            sb.push_back('{k, k + 1});
        end
        vin = 4'b1111;
        tick;
        vin = '0;
        tick;
        for (int k = 0; k < N_CH; k++) begin
            chk("rr_vout", int'(vout), 1);
            chk("rr_ch", int'(dout_ch), k);
            tick;
        end
        chk("rr_done", int'(vout), 0);
        chk("rr_sb_empty", sb.size(), 0);

        // backpressure: fill FIFO and holding register, drop three, set beats clear
        do_reset;
        rdy = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            set_din(0, 64 * k);
            vin = 4'b0001;
            if (k <= 9)
                sb.push_back('{0, k});
            tick;
        end
        vin = '0;
        tick;
        tick;
        chk("bp_level", int'(level), 8);
        chk("bp_ovf", int'(ovf), 1);
        chk("bp_head", int'(dout), 1);
        set_din(0, 64 * 13);
        vin = 4'b0001;
        clr_ovf = 1'b1;
        tick;
        vin = '0;
        clr_ovf = 1'b0;
        chk("ovf_set_wins", int'(ovf), 1);
        chk("bp_level_hold", int'(level), 8);
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        chk("ovf_clear", int'(ovf), 0);
        rdy = 1'b1;
        wait_level(0, 30);
        chk("bp_sb_empty", sb.size(), 0);

        // full FIFO with continuous push and pop keeps level at DEPTH
        do_reset;
        rdy = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            set_din(1, 64 * k);
            vin = 4'b0010;
            sb.push_back('{1, k});
            tick;
        end
        vin = '0;
        tick;
        chk("fp_level", int'(level), 8);
        rdy = 1'b1;
        for (int k = 10; k <= 15; k++) begin
            set_din(1, 64 * k);
            vin = 4'b0010;
            sb.push_back('{1, k});
            tick;
            chk("fp_level_full", int'(level), 8);
        end
        vin = '0;
        wait_level(0, 30);
        chk("fp_sb_empty", sb.size(), 0);
        chk("fp_ovf", int'(ovf), 0);

        // asynchronous reset at level 5 with a drop flag raised
        do_reset;
        rdy = 1'b0;
        set_din(0, 64);
        set_din(1, 128);
        vin = 4'b0011;
        tick;
        tick;
        set_din(2, 192);
        vin = 4'b0100;
        tick;
        tick;
        vin = '0;
        wait_level(5, 10);
        chk("mr_ovf", int'(ovf), 2);
        reset = 1'b1;
        #1;
        chk("mr_vout", int'(vout), 0);
        chk("mr_level", int'(level), 0);
        chk("mr_ovf_clr", int'(ovf), 0);
        chk("mr_dout", int'(dout), 0);
        #1;
        reset = 1'b0;
        sb.delete();
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("mr_no_out", int'(vout), 0);
        end
        set_din(3, 4032);
        vin = 4'b1000;
        sb.push_back('{3, 'h3F});
        tick;
        vin = '0;
        tick;
        chk("mr_after_vout", int'(vout), 1);
        tick;
        tick;
        chk("mr_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
